// File: rtl/avl_pkg.sv
// Shared types and constants for the Avalon-MM burst memory slave.
package avl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WR_BURST = 2'd1,
        RD_BURST = 2'd2
    } state_t;

    // Byte-enable lanes for a given data width.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/avl_be_ram.sv
// Single-port byte-enabled RAM with a registered synchronous read port.
module avl_be_ram
    import avl_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [ADDR_W-1:0]           address,
    input  logic [be_width(DATA_W)-1:0] we,
    input  logic [DATA_W-1:0]           wdata,
    input  logic                        re,
    output logic [DATA_W-1:0]           rdata
);

    localparam int BE_W  = be_width(DATA_W);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive avl_rst.
    always_ff @(posedge clk) begin
        for (int b = 0; b < BE_W; b++) begin
            if (we[b]) begin
                mem[address][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[address];
        end
    end

endmodule

// File: rtl/avl_burst_mem_slave.sv
// Avalon-MM burst-capable terminal memory slave: burst FSM around a byte-enabled RAM,
// one-cycle registered read latency, waitrequest only while a read burst streams out.
module avl_burst_mem_slave
    import avl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 10,
    parameter int BURST_W = 8
) (
    input  logic                        avl_clk,
    input  logic                        avl_rst,
    input  logic [ADDR_W-1:0]           avl_address,
    input  logic                        avl_read,
    input  logic                        avl_write,
    input  logic [DATA_W-1:0]           avl_writedata,
    input  logic [be_width(DATA_W)-1:0] avl_byteenable,
    input  logic [BURST_W-1:0]          avl_burstcount,
    input  logic                        avl_beginbursttransfer,
    output logic                        avl_waitrequest,
    output logic [DATA_W-1:0]           avl_readdata,
    output logic                        avl_readdatavalid
);

    localparam int BE_W = be_width(DATA_W);

    state_t               state, state_nxt;
    logic [ADDR_W-1:0]    addr, addr_nxt;
    logic [BURST_W-1:0]   remaining, remaining_nxt;
    logic [BURST_W-1:0]   beats;
    logic [ADDR_W-1:0]    ram_addr;
    logic [BE_W-1:0]      ram_we;
    logic                 ram_re;
    logic                 unused_ok;

    // Bursts are framed by burstcount alone.
    assign unused_ok = avl_beginbursttransfer;

    assign beats = (avl_burstcount == '0) ? BURST_W'(1) : avl_burstcount;

    assign avl_waitrequest = (state == RD_BURST);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt     = state;
        addr_nxt      = addr;
        remaining_nxt = remaining;
        ram_addr      = addr;
        ram_we        = '0;
        ram_re        = 1'b0;

        case (state)
            IDLE: begin
                ram_addr = avl_address;
                // A write wins over a simultaneous read; the read is dropped.
                if (avl_write) begin
                    ram_we = avl_byteenable;
                    if (beats > BURST_W'(1)) begin
                        addr_nxt      = avl_address + ADDR_W'(1);
                        remaining_nxt = beats - BURST_W'(1);
                        state_nxt     = WR_BURST;
                    end
                end else if (avl_read) begin
                    ram_re = 1'b1;
                    if (beats > BURST_W'(1)) begin
                        addr_nxt      = avl_address + ADDR_W'(1);
                        remaining_nxt = beats - BURST_W'(1);
                        state_nxt     = RD_BURST;
                    end
                end
            end

            WR_BURST: begin
                if (avl_write) begin
                    ram_we        = avl_byteenable;
                    addr_nxt      = addr + ADDR_W'(1);
                    remaining_nxt = remaining - BURST_W'(1);
                    if (remaining == BURST_W'(1)) begin
                        state_nxt = IDLE;
                    end
                end
            end

            RD_BURST: begin
                ram_re        = 1'b1;
                addr_nxt      = addr + ADDR_W'(1);
                remaining_nxt = remaining - BURST_W'(1);
                if (remaining == BURST_W'(1)) begin
                    state_nxt = IDLE;
                end
            end

            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge avl_clk or posedge avl_rst) begin
        if (avl_rst) begin
            state             <= IDLE;
            addr              <= '0;
            remaining         <= '0;
            avl_readdatavalid <= 1'b0;
        end else begin
            state             <= state_nxt;
            addr              <= addr_nxt;
            remaining         <= remaining_nxt;
            avl_readdatavalid <= ram_re;
        end
    end

    avl_be_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (avl_clk),
        .rst     (avl_rst),
        .address (ram_addr),
        .we      (ram_we),
        .wdata   (avl_writedata),
        .re      (ram_re),
        .rdata   (avl_readdata)
    );

endmodule

// File: tb/tb_avl_burst_mem_slave.sv
// Directed bench for avl_burst_mem_slave: single-beat vector table plus burst,
// wrap, stall and mid-burst reset sequences.
module tb_avl_burst_mem_slave;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 10;
    localparam int BURST_W = 8;
    localparam int BE_W    = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic [ADDR_W-1:0]  address;
    logic               read;
    logic               write;
    logic [DATA_W-1:0]  writedata;
    logic [BE_W-1:0]    byteenable;
    logic [BURST_W-1:0] burstcount;
    logic               beginbursttransfer;
    logic               waitrequest;
    logic [DATA_W-1:0]  readdata;
    logic               readdatavalid;

    int n_vec  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    avl_burst_mem_slave #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .BURST_W (BURST_W)
    ) dut (
        .avl_clk                (clk),
        .avl_rst                (rst),
        .avl_address            (address),
        .avl_read               (read),
        .avl_write              (write),
        .avl_writedata          (writedata),
        .avl_byteenable         (byteenable),
        .avl_burstcount         (burstcount),
        .avl_beginbursttransfer (beginbursttransfer),
        .avl_waitrequest        (waitrequest),
        .avl_readdata           (readdata),
        .avl_readdatavalid      (readdatavalid)
    );

    typedef struct {
        logic               wr;
        logic               rd;
        logic [ADDR_W-1:0]  addr;
        logic [DATA_W-1:0]  wdata;
        logic [BE_W-1:0]    be;
        logic [BURST_W-1:0] bc;
        logic               exp_valid;
        logic [DATA_W-1:0]  exp_rdata;
        logic               exp_wait;
    } vec_t;

    function automatic vec_t mk(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                                input logic [BURST_W-1:0] bc, input logic ev,
                                input logic [DATA_W-1:0] er, input logic ew);
        vec_t v;
        v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d; v.be = be; v.bc = bc;
        v.exp_valid = ev; v.exp_rdata = er; v.exp_wait = ew;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check(name, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic drive(input logic wr, input logic rd, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, input logic [BE_W-1:0] be,
                         input logic [BURST_W-1:0] bc);
        write = wr; read = rd; address = a; writedata = d; byteenable = be; burstcount = bc;
        beginbursttransfer = (wr | rd);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0, 8'd1);
        beginbursttransfer = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_burst(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            if (i == 0) drive(1'b1, 1'b0, a, base, 4'hF, 8'(n));
            else        drive(1'b1, 1'b0, '0, base + 32'(i), 4'hF, 8'd0);
            step();
            check_bit($sformatf("wr_burst@%0d beat%0d wait", a, i), waitrequest, 1'b0);
        end
        idle();
    endtask

    task automatic rd_single(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] exp);
        drive(1'b0, 1'b1, a, '0, '0, 8'd1);
        step();
        idle();
        check_bit($sformatf("rd%0d valid", a), readdatavalid, 1'b1);
        check($sformatf("rd%0d data", a), readdata, exp);
    endtask

    vec_t vecs [15];

    initial begin
        int nwait;

        vecs[0]  = mk(1, 0, 10'd5, 32'hDEADBEEF, 4'hF, 8'd1, 0, 32'h0,        0);
        vecs[1]  = mk(0, 1, 10'd5, 32'h0,        4'h0, 8'd1, 1, 32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 0, 10'd7, 32'h11223344, 4'hF, 8'd1, 0, 32'hDEADBEEF, 0);
        vecs[3]  = mk(1, 0, 10'd7, 32'hAABBCCDD, 4'h5, 8'd1, 0, 32'hDEADBEEF, 0);
        vecs[4]  = mk(0, 1, 10'd7, 32'h0,        4'h0, 8'd1, 1, 32'h11BB33DD, 0);
        vecs[5]  = mk(1, 1, 10'd3, 32'h00000055, 4'hF, 8'd1, 0, 32'h11BB33DD, 0);
        vecs[6]  = mk(0, 1, 10'd3, 32'h0,        4'h0, 8'd1, 1, 32'h00000055, 0);
        vecs[7]  = mk(0, 1, 10'd5, 32'h0,        4'h0, 8'd1, 1, 32'hDEADBEEF, 0);
        vecs[8]  = mk(1, 0, 10'd5, 32'hFFFFFFFF, 4'h0, 8'd1, 0, 32'hDEADBEEF, 0);
        vecs[9]  = mk(0, 1, 10'd5, 32'h0,        4'h0, 8'd1, 1, 32'hDEADBEEF, 0);
        vecs[10] = mk(1, 0, 10'd9, 32'h12345678, 4'hF, 8'd0, 0, 32'hDEADBEEF, 0);
        vecs[11] = mk(0, 1, 10'd9, 32'h0,        4'h0, 8'd0, 1, 32'h12345678, 0);
        vecs[12] = mk(0, 0, 10'd0, 32'h0,        4'h0, 8'd1, 0, 32'h12345678, 0);
        vecs[13] = mk(1, 0, 10'd9, 32'hCAFEF00D, 4'h8, 8'd1, 0, 32'h12345678, 0);
        vecs[14] = mk(0, 1, 10'd9, 32'h0,        4'h0, 8'd1, 1, 32'hCA345678, 0);

        rst = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check_bit("reset valid", readdatavalid, 1'b0);
        check_bit("reset wait", waitrequest, 1'b0);
        check("reset rdata", readdata, 32'h0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].bc);
            step();
            check_bit($sformatf("vec%0d valid", i), readdatavalid, vecs[i].exp_valid);
            check($sformatf("vec%0d rdata", i), readdata, vecs[i].exp_rdata);
            check_bit($sformatf("vec%0d wait", i), waitrequest, vecs[i].exp_wait);
        end
        idle();

        // Write burst N=4 at 1020 with an idle beat after beat 1.
        drive(1'b1, 1'b0, 10'd1020, 32'd1, 4'hF, 8'd4);
        step(); check_bit("wb beat0 wait", waitrequest, 1'b0);
        drive(1'b1, 1'b0, 10'd0, 32'd2, 4'hF, 8'd0);
        step(); check_bit("wb beat1 wait", waitrequest, 1'b0);
        drive(1'b0, 1'b0, 10'd0, 32'hFFFF, 4'hF, 8'd0);
        step(); check_bit("wb gap wait", waitrequest, 1'b0);
        drive(1'b1, 1'b0, 10'd0, 32'd3, 4'hF, 8'd0);
        step(); check_bit("wb beat2 wait", waitrequest, 1'b0);
        drive(1'b1, 1'b0, 10'd0, 32'd4, 4'hF, 8'd0);
        step(); check_bit("wb beat3 wait", waitrequest, 1'b0);

        // Read burst N=4 at 1020.
        drive(1'b0, 1'b1, 10'd1020, '0, '0, 8'd4);
        step();
        idle();
        nwait = 0;
        for (int i = 0; i < 4; i++) begin
            check_bit($sformatf("rb beat%0d valid", i), readdatavalid, 1'b1);
            check($sformatf("rb beat%0d data", i), readdata, 32'(i + 1));
            if (waitrequest) nwait++;
            step();
        end
        check_bit("rb after valid", readdatavalid, 1'b0);
        check("rb after data hold", readdata, 32'd4);
        check("rb wait cycles", 32'(nwait), 32'd3);

        // Wrap burst at 1022 touches 1022, 1023, 0, 1.
        wr_burst(10'd1022, 32'hA0, 4);
        rd_single(10'd1022, 32'hA0);
        rd_single(10'd1023, 32'hA1);
        rd_single(10'd0,    32'hA2);
        rd_single(10'd1,    32'hA3);
        rd_single(10'd1021, 32'd2);

        // Read burst N=3 with read and write held high through the stall.
        wr_burst(10'd20, 32'hC20, 4);
        drive(1'b0, 1'b1, 10'd20, '0, '0, 8'd3);
        step();
        drive(1'b1, 1'b1, 10'd23, 32'h0BAD, 4'hF, 8'd1);
        check_bit("stall T+1 wait", waitrequest, 1'b1);
        check("stall T+1 data", readdata, 32'hC20);
        step();
        check_bit("stall T+2 wait", waitrequest, 1'b1);
        check("stall T+2 data", readdata, 32'hC21);
        step();
        check_bit("stall T+3 wait", waitrequest, 1'b0);
        check_bit("stall T+3 valid", readdatavalid, 1'b1);
        check("stall T+3 data", readdata, 32'hC22);
        drive(1'b1, 1'b0, 10'd24, 32'h00C0FFEE, 4'hF, 8'd1);
        step();
        idle();
        check_bit("stall after valid", readdatavalid, 1'b0);
        rd_single(10'd23, 32'hC23);
        rd_single(10'd24, 32'h00C0FFEE);

        // Reset during beat 2 of a read burst N=8.
        wr_burst(10'd40, 32'h40000000, 8);
        drive(1'b0, 1'b1, 10'd40, '0, '0, 8'd8);
        step();
        idle();
        check("rst burst beat0", readdata, 32'h40000000);
        step();
        check("rst burst beat1", readdata, 32'h40000001);
        step();
        check("rst burst beat2", readdata, 32'h40000002);
        rst = 1'b1;
        #1;
        check_bit("rst mid valid", readdatavalid, 1'b0);
        check_bit("rst mid wait", waitrequest, 1'b0);
        check("rst mid rdata", readdata, 32'h0);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_bit($sformatf("post rst%0d valid", i), readdatavalid, 1'b0);
            check_bit($sformatf("post rst%0d wait", i), waitrequest, 1'b0);
        end
        rd_single(10'd41, 32'h40000001);
        rd_single(10'd47, 32'h40000007);
        rd_single(10'd5,  32'hDEADBEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
